// File: rtl/cpu6_seq_pkg.sv
// Shared definitions for the CPU6 microprogram sequencer: op encodings and
// default geometry.
package cpu6_seq_pkg;

  localparam int SEQ_ADDR_W      = 11;
  localparam int SEQ_STACK_DEPTH = 4;

  localparam logic [2:0] SEQ_CONT = 3'd0;
  localparam logic [2:0] SEQ_CJP  = 3'd1;
  localparam logic [2:0] SEQ_CJS  = 3'd2;
  localparam logic [2:0] SEQ_CRTN = 3'd3;
  localparam logic [2:0] SEQ_LDCT = 3'd4;
  localparam logic [2:0] SEQ_RPCT = 3'd5;
  localparam logic [2:0] SEQ_PUSH = 3'd6;
  localparam logic [2:0] SEQ_LOOP = 3'd7;

endpackage

// File: rtl/seq_stack.sv
// Return-address LIFO for the microprogram sequencer with full/empty status
// and a sticky over/underflow flag.
module seq_stack #(
  parameter  int DEPTH = 4,
  parameter  int W     = 11,
  localparam int SP_W  = $clog2(DEPTH + 1),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    tos,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty,
  output logic            err
);

  logic [W-1:0]     mem [DEPTH];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;

  assign full   = (sp == SP_W'(DEPTH));
  assign empty  = (sp == '0);
  assign rd_idx = empty ? '0 : IDX_W'(sp - SP_W'(1));
  // A push into a full stack lands on the top entry instead of running off the end.
  assign wr_idx = full ? IDX_W'(DEPTH - 1) : IDX_W'(sp);
  assign tos    = mem[rd_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp  <= '0;
      err <= 1'b0;
    end else if (push) begin
      if (full) err <= 1'b1;
      else      sp  <= sp + SP_W'(1);
    end else if (pop) begin
      if (empty) err <= 1'b1;
      else       sp  <= sp - SP_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/ucode_sequencer.sv
// Next-microaddress sequencer: conditional jump/call/return, loop counter and
// case OR-mask in front of the microcode ROM address input.
module ucode_sequencer
  import cpu6_seq_pkg::*;
#(
  parameter int ADDR_W      = SEQ_ADDR_W,
  parameter int STACK_DEPTH = SEQ_STACK_DEPTH,
  parameter int CNT_W       = ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] d_in,
  input  logic [ADDR_W-1:0] or_in,
  input  logic              case_en,
  input  logic              cc_en,
  input  logic              cond,
  input  logic              cc_pol,
  input  logic              inc,
  input  logic              hold,
  output logic [ADDR_W-1:0] y_out,
  output logic              cnt_zero,
  output logic              stack_full,
  output logic              stack_err
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] upc;
  logic [CNT_W-1:0]  cnt;
  logic              pass;
  logic [ADDR_W-1:0] y_src;
  logic [ADDR_W-1:0] y_mux;
  logic              push;
  logic              pop;
  logic              cnt_ld;
  logic              cnt_dec;
  logic [ADDR_W-1:0] stk_tos;
  logic [ADDR_W-1:0] tos_val;
  logic [SP_W-1:0]   stk_sp;
  logic              stk_full;
  logic              stk_empty;

  assign pass    = cc_en ? (cond ^ cc_pol) : 1'b1;
  assign tos_val = (stk_sp == '0) ? '0 : stk_tos;

  always_comb begin
    y_src   = upc;
    push    = 1'b0;
    pop     = 1'b0;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    case (op)
      SEQ_CONT: ;
      SEQ_CJP:  if (pass) y_src = d_in;
      SEQ_CJS:  if (pass) begin y_src = d_in; push = 1'b1; end
      SEQ_CRTN: if (pass) begin y_src = tos_val; pop = 1'b1; end
      SEQ_LDCT: cnt_ld = 1'b1;
      SEQ_RPCT: if (cnt != '0) begin y_src = d_in; cnt_dec = 1'b1; end
      SEQ_PUSH: begin push = 1'b1; cnt_ld = pass; end
      SEQ_LOOP: begin
        if (pass) pop = 1'b1;
        else begin
          y_src = tos_val;
          // Reading an empty stack must flag an error without moving sp,
          // which is exactly what an underflowing pop does.
          pop   = stk_empty;
        end
      end
      default: ;
    endcase
  end

  assign y_mux      = case_en ? (y_src | or_in) : y_src;
  assign y_out      = reset ? '0 : y_mux;
  assign cnt_zero   = (cnt == '0);
  assign stack_full = stk_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      upc <= '0;
      cnt <= '0;
    end else if (!hold) begin
      upc <= y_out + ADDR_W'(inc);
      if (cnt_ld)       cnt <= CNT_W'(d_in);
      else if (cnt_dec) cnt <= cnt - CNT_W'(1);
    end
  end

  seq_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .push  (push & ~hold),
    .pop   (pop & ~hold),
    .din   (upc),
    .tos   (stk_tos),
    .sp    (stk_sp),
    .full  (stk_full),
    .empty (stk_empty),
    .err   (stack_err)
  );

endmodule

// File: tb/tb_ucode_sequencer.sv
// Scoreboard bench for ucode_sequencer: a queue-based reference model predicts
// each cycle's outputs, a negedge monitor compares them against the DUT.
module tb_ucode_sequencer;

  localparam int AW    = 11;
  localparam int DEPTH = 4;
  localparam int MASK  = (1 << AW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    op = 3'd0;
  logic [AW-1:0] d_in = '0;
  logic [AW-1:0] or_in = '0;
  logic          case_en = 1'b0;
  logic          cc_en = 1'b0;
  logic          cond = 1'b0;
  logic          cc_pol = 1'b0;
  logic          inc = 1'b1;
  logic          hold = 1'b0;
  logic [AW-1:0] y_out;
  logic          cnt_zero;
  logic          stack_full;
  logic          stack_err;

  ucode_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .op         (op),
    .d_in       (d_in),
    .or_in      (or_in),
    .case_en    (case_en),
    .cc_en      (cc_en),
    .cond       (cond),
    .cc_pol     (cc_pol),
    .inc        (inc),
    .hold       (hold),
    .y_out      (y_out),
    .cnt_zero   (cnt_zero),
    .stack_full (stack_full),
    .stack_err  (stack_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int y;
    bit cz;
    bit full;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  int mupc = 0;
  int mcnt = 0;
  bit merr = 1'b0;
  int mstk[$];

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (int'(y_out) != e.y) begin
        bad++;
        $display("FAIL y_out t=%0t got %03h want %03h", $time, y_out, e.y);
      end
      total++;
      if (cnt_zero !== e.cz) begin
        bad++;
        $display("FAIL cnt_zero t=%0t got %b want %b", $time, cnt_zero, e.cz);
      end
      total++;
      if (stack_full !== e.full) begin
        bad++;
        $display("FAIL stack_full t=%0t got %b want %b", $time, stack_full, e.full);
      end
      total++;
      if (stack_err !== e.err) begin
        bad++;
        $display("FAIL stack_err t=%0t got %b want %b", $time, stack_err, e.err);
      end
    end
  end

  function automatic void m_push(int v);
    if (mstk.size() == DEPTH) begin
      mstk[DEPTH-1] = v;
      merr = 1'b1;
    end else begin
      mstk.push_back(v);
    end
  endfunction

  function automatic void m_pop();
    if (mstk.size() == 0) merr = 1'b1;
    else void'(mstk.pop_back());
  endfunction

  // Predict this cycle from current inputs, queue it, then advance one edge.
  task automatic cycle();
    exp_t e;
    int   y, tos, ncnt;
    bit   pass, dpush, dpop, rd_empty;
    if (reset) begin
      e = '{y: 0, cz: 1'b1, full: 1'b0, err: 1'b0};
      exp_q.push_back(e);
      @(posedge clock); #1;
      mupc = 0; mcnt = 0; merr = 1'b0; mstk.delete();
      return;
    end
    e.cz   = (mcnt == 0);
    e.full = (mstk.size() == DEPTH);
    e.err  = merr;
    pass   = cc_en ? (cond ^ cc_pol) : 1'b1;
    tos    = (mstk.size() > 0) ? mstk[$] : 0;
    dpush = 0; dpop = 0; rd_empty = 0; ncnt = mcnt; y = mupc;
    case (op)
      3'd1: if (pass) y = d_in;
      3'd2: if (pass) begin y = d_in; dpush = 1; end
      3'd3: if (pass) begin y = tos; dpop = 1; end
      3'd4: ncnt = d_in;
      3'd5: if (mcnt != 0) begin y = d_in; ncnt = mcnt - 1; end
      3'd6: begin dpush = 1; if (pass) ncnt = d_in; end
      3'd7: if (pass) dpop = 1;
            else begin y = tos; rd_empty = (mstk.size() == 0); end
      default: ;
    endcase
    if (case_en) y = y | int'(or_in);
    y &= MASK;
    e.y = y;
    exp_q.push_back(e);
    @(posedge clock); #1;
    if (!hold) begin
      if (dpush) m_push(mupc);
      if (dpop) m_pop();
      if (rd_empty) merr = 1'b1;
      mupc = (y + int'(inc)) & MASK;
      mcnt = ncnt;
    end
  endtask

  task automatic set_op(logic [2:0] o, int d, bit ce = 0, bit c = 0);
    op = o; d_in = AW'(d); cc_en = ce; cond = c;
    cc_pol = 0; case_en = 0; or_in = '0; hold = 0; inc = 1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    set_op(3'd0, 0);
    cycle();
    reset = 1'b0;
    repeat (4) cycle();                        // y 0,1,2,3
    set_op(3'd1, 'h101, 1, 0); cycle();        // fails -> upc
    set_op(3'd1, 'h101, 1, 1); cycle();        // 0x101
    set_op(3'd0, 0); cycle();                  // 0x102
    set_op(3'd1, 'h00F); cycle();              // upc becomes 0x010
    set_op(3'd2, 'h200); cycle();
    set_op(3'd0, 0); cycle(); cycle();
    set_op(3'd3, 0); cycle();                  // returns 0x010
    set_op(3'd4, 3); cycle();
    set_op(3'd5, 'h050); repeat (4) cycle();   // 0x050 x3, then upc
    set_op(3'd1, 0); cycle();                  // upc becomes 1
    for (int k = 1; k <= 5; k++) begin
      set_op(3'd2, k); cycle();                // pushes 1..5, last overwrites TOS
    end
    set_op(3'd3, 0); repeat (4) cycle();       // 5,3,2,1
    set_op(3'd0, 0); hold = 1; cycle(); cycle();
    hold = 0; cycle();
    set_op(3'd3, 0); cycle();                  // pop at empty -> 0
    set_op(3'd1, 'h100); case_en = 1; or_in = AW'(3); cycle();  // 0x103
    set_op(3'd7, 0, 1, 0); cycle();            // LOOP fail at empty
    set_op(3'd4, 3); cycle();
    set_op(3'd5, 'h050); cycle();
    reset = 1'b1; cycle();                     // reset mid-RPCT
    reset = 1'b0; set_op(3'd0, 0); cycle();

    for (int i = 0; i < 3000; i++) begin
      op      = 3'($urandom_range(0, 7));
      d_in    = AW'($urandom);
      or_in   = AW'($urandom);
      case_en = ($urandom_range(0, 7) == 0);
      cc_en   = 1'($urandom);
      cond    = 1'($urandom);
      cc_pol  = 1'($urandom);
      inc     = ($urandom_range(0, 7) != 0);
      hold    = ($urandom_range(0, 7) == 0);
      reset   = ($urandom_range(0, 63) == 0);
      if (op == 3'd4 || (op == 3'd6 && $urandom_range(0, 1) == 0))
        d_in = AW'($urandom_range(0, 6));
      cycle();
    end
    reset = 1'b0;

    repeat (3) @(negedge clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
